// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue: OTTER instruction-fetch front end with a small prefetch queue.
// Owns the fetch PC and issues at most one sync read per cycle on memory port 1.
// Each response is queued as a {PC, IR} pair for decode, which uses a valid/ready
// handshake. A redirect flushes the queue and drops the response still in flight.
module otter_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_RD,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DOUT,
  output logic        IF_VALID,
  output logic [31:0] IF_IR,
  output logic [31:0] IF_PC,
  input  logic        DE_READY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_CREDIT = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_COUNT  = CW'(DEPTH);
  localparam logic [31:0]   NOP          = 32'h0000_0013;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   tag_pc_q, tag_pc_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;

  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   ir_mem_q [DEPTH];

  logic [CW:0]   credit_used;
  logic          issue;
  logic          push;
  logic          pop;

  // The two low redirect bits are forced to zero, so they are deliberately dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  // Head outputs come straight from stored entries; IMEM_DOUT never bypasses to decode.
  always_comb begin
    IF_VALID  = (count_q != '0);
    IF_IR     = IF_VALID ? ir_mem_q[rptr_q] : NOP;
    IF_PC     = IF_VALID ? pc_mem_q[rptr_q] : 32'h0;
    IMEM_ADDR = fpc_q;
    IMEM_RD   = issue;
  end

  // Credit check, handshake decode and next-state; redirect overrides everything else.
  always_comb begin
    credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue       = RESET_N && !REDIRECT && (credit_used < DEPTH_CREDIT);
    push        = inflight_q && !REDIRECT;
    pop         = IF_VALID && DE_READY && !REDIRECT;

    fpc_d      = fpc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    if (REDIRECT) begin
      fpc_d   = {REDIRECT_PC[31:2], 2'b00};
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (issue) begin
        fpc_d    = fpc_q + 32'd4;
        tag_pc_d = fpc_q;
      end
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset restarts fetching at RESET_PC with an empty queue.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fpc_q      <= RESET_PC;
      tag_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fpc_q      <= fpc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Queue storage; a response is captured only when it survives redirect and reset.
  always_ff @(posedge CLK) begin
    if (RESET_N && push) begin
      pc_mem_q[wptr_q] <= tag_pc_q;
      ir_mem_q[wptr_q] <= IMEM_DOUT;
    end
  end

`ifndef SYNTHESIS
  // The issue credit rule means a full queue never sees a push without a matching pop.
  always_ff @(posedge CLK) begin
    if (RESET_N) assert (!(push && !pop && (count_q == DEPTH_COUNT)));
  end
`endif

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Directed bench for otter_fetch_queue with a 1-cycle sync memory returning IR = address.
module tb_otter_fetch_queue;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_RD;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DOUT;
  logic        IF_VALID;
  logic [31:0] IF_IR;
  logic [31:0] IF_PC;
  logic        DE_READY;

  int n_cmp = 0;
  int n_err = 0;

  otter_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK         (clk),
    .RESET_N     (RESET_N),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IMEM_RD     (IMEM_RD),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_DOUT   (IMEM_DOUT),
    .IF_VALID    (IF_VALID),
    .IF_IR       (IF_IR),
    .IF_PC       (IF_PC),
    .DE_READY    (DE_READY)
  );

  always #5 clk = ~clk;

  // Memory model: data for a read appears the cycle after IMEM_RD, equal to the address.
  always @(posedge clk) begin
    if (IMEM_RD) IMEM_DOUT <= IMEM_ADDR;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Holds reset for two edges; the caller releases it in the cycle it wants as cycle 1.
  task automatic do_reset();
    RESET_N  = 1'b0;
    REDIRECT = 1'b0;
    REDIRECT_PC = 32'h0;
    tick();
    tick();
  endtask

  initial begin
    RESET_N     = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'h0;
    DE_READY    = 1'b1;
    IMEM_DOUT   = 32'h0;

    // Test 1: reset state, then sustained stream with DE_READY=1.
    do_reset();
    settle();
    check_eq("t1 rst rd", {31'b0, IMEM_RD}, 32'd0);
    check_eq("t1 rst addr", IMEM_ADDR, 32'h0);
    check_eq("t1 rst valid", {31'b0, IF_VALID}, 32'd0);
    check_eq("t1 rst ir", IF_IR, 32'h13);
    check_eq("t1 rst pc", IF_PC, 32'h0);
    RESET_N = 1'b1;
    settle();
    check_eq("t1 c1 rd", {31'b0, IMEM_RD}, 32'd1);
    check_eq("t1 c1 addr", IMEM_ADDR, 32'h0);
    check_eq("t1 c1 valid", {31'b0, IF_VALID}, 32'd0);
    tick(); settle();
    check_eq("t1 c2 rd", {31'b0, IMEM_RD}, 32'd1);
    check_eq("t1 c2 addr", IMEM_ADDR, 32'h4);
    check_eq("t1 c2 valid", {31'b0, IF_VALID}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      check_eq($sformatf("t1 c%0d valid", k + 3), {31'b0, IF_VALID}, 32'd1);
      check_eq($sformatf("t1 c%0d pc", k + 3), IF_PC, 32'(4 * k));
      check_eq($sformatf("t1 c%0d ir", k + 3), IF_IR, 32'(4 * k));
      check_eq($sformatf("t1 c%0d rd", k + 3), {31'b0, IMEM_RD}, 32'd1);
      check_eq($sformatf("t1 c%0d addr", k + 3), IMEM_ADDR, 32'(4 * k + 8));
    end

    // Test 2: decode stalled from start; exactly four reads, then drain in order.
    DE_READY = 1'b0;
    do_reset();
    RESET_N = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      settle();
      check_eq($sformatf("t2 c%0d rd", c), {31'b0, IMEM_RD}, (c <= 4) ? 32'd1 : 32'd0);
      if (c <= 4) check_eq($sformatf("t2 c%0d addr", c), IMEM_ADDR, 32'(4 * (c - 1)));
      if (c >= 6) begin
        check_eq($sformatf("t2 c%0d pc", c), IF_PC, 32'h0);
        check_eq($sformatf("t2 c%0d ir", c), IF_IR, 32'h0);
      end
      tick();
    end
    DE_READY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      check_eq($sformatf("t2 drain%0d valid", k), {31'b0, IF_VALID}, 32'd1);
      check_eq($sformatf("t2 drain%0d pc", k), IF_PC, 32'(4 * k));
      check_eq($sformatf("t2 drain%0d ir", k), IF_IR, 32'(4 * k));
      if (k == 0) check_eq("t2 drain0 rd", {31'b0, IMEM_RD}, 32'd0);
      if (k == 1) begin
        check_eq("t2 resume rd", {31'b0, IMEM_RD}, 32'd1);
        check_eq("t2 resume addr", IMEM_ADDR, 32'h10);
      end
      tick();
    end

    // Test 3: three queued + one in flight, redirect to 0x100 flushes everything.
    DE_READY = 1'b0;
    do_reset();
    RESET_N = 1'b1;
    for (int c = 1; c <= 4; c++) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    settle();
    check_eq("t3 pre valid", {31'b0, IF_VALID}, 32'd1);
    check_eq("t3 r rd", {31'b0, IMEM_RD}, 32'd0);
    tick();
    REDIRECT = 1'b0; DE_READY = 1'b1;
    settle();
    check_eq("t3 r1 valid", {31'b0, IF_VALID}, 32'd0);
    check_eq("t3 r1 ir", IF_IR, 32'h13);
    check_eq("t3 r1 pc", IF_PC, 32'h0);
    check_eq("t3 r1 rd", {31'b0, IMEM_RD}, 32'd1);
    check_eq("t3 r1 addr", IMEM_ADDR, 32'h100);
    tick(); settle();
    check_eq("t3 r2 valid", {31'b0, IF_VALID}, 32'd0);
    check_eq("t3 r2 addr", IMEM_ADDR, 32'h104);
    tick(); settle();
    check_eq("t3 r3 valid", {31'b0, IF_VALID}, 32'd1);
    check_eq("t3 r3 pc", IF_PC, 32'h100);
    check_eq("t3 r3 ir", IF_IR, 32'h100);
    tick(); settle();
    check_eq("t3 r4 pc", IF_PC, 32'h104);

    // Test 4: redirect with a valid head and DE_READY high: flush only.
    DE_READY = 1'b1;
    do_reset();
    RESET_N = 1'b1;
    for (int c = 1; c <= 3; c++) tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    settle();
    check_eq("t4 r valid", {31'b0, IF_VALID}, 32'd1);
    check_eq("t4 r pc", IF_PC, 32'h4);
    check_eq("t4 r rd", {31'b0, IMEM_RD}, 32'd0);
    tick();
    REDIRECT = 1'b0;
    settle();
    check_eq("t4 r1 valid", {31'b0, IF_VALID}, 32'd0);
    tick(); settle();
    check_eq("t4 r2 valid", {31'b0, IF_VALID}, 32'd0);
    tick();
    DE_READY = 1'b0;
    settle();
    check_eq("t4 r3 pc", IF_PC, 32'h100);
    tick(); settle();
    check_eq("t4 r4 hold pc", IF_PC, 32'h100);
    DE_READY = 1'b1;
    tick(); settle();
    check_eq("t4 r5 pc", IF_PC, 32'h104);

    // Test 5: unaligned target, then back-to-back redirects; only the last is fetched.
    REDIRECT = 1'b1; REDIRECT_PC = 32'h103;
    tick();
    REDIRECT = 1'b0;
    settle();
    check_eq("t5 align rd", {31'b0, IMEM_RD}, 32'd1);
    check_eq("t5 align addr", IMEM_ADDR, 32'h100);
    tick();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    settle();
    check_eq("t5 r rd", {31'b0, IMEM_RD}, 32'd0);
    tick();
    REDIRECT_PC = 32'h300;
    settle();
    check_eq("t5 r1 rd", {31'b0, IMEM_RD}, 32'd0);
    check_eq("t5 r1 valid", {31'b0, IF_VALID}, 32'd0);
    tick();
    REDIRECT = 1'b0;
    settle();
    check_eq("t5 r2 addr", IMEM_ADDR, 32'h300);
    check_eq("t5 r2 valid", {31'b0, IF_VALID}, 32'd0);
    tick(); settle();
    check_eq("t5 r3 valid", {31'b0, IF_VALID}, 32'd0);
    tick(); settle();
    check_eq("t5 r4 pc", IF_PC, 32'h300);
    check_eq("t5 r4 ir", IF_IR, 32'h300);
    tick(); settle();
    check_eq("t5 r5 pc", IF_PC, 32'h304);

    // Test 6: reset mid-stream with two queued and one in flight.
    DE_READY = 1'b0;
    do_reset();
    RESET_N = 1'b1;
    for (int c = 1; c <= 3; c++) tick();
    RESET_N = 1'b0;
    settle();
    check_eq("t6 pre valid", {31'b0, IF_VALID}, 32'd1);
    check_eq("t6 rst rd", {31'b0, IMEM_RD}, 32'd0);
    tick(); settle();
    check_eq("t6 n1 valid", {31'b0, IF_VALID}, 32'd0);
    check_eq("t6 n1 ir", IF_IR, 32'h13);
    check_eq("t6 n1 pc", IF_PC, 32'h0);
    check_eq("t6 n1 addr", IMEM_ADDR, 32'h0);
    check_eq("t6 n1 rd", {31'b0, IMEM_RD}, 32'd0);
    tick();
    RESET_N = 1'b1; DE_READY = 1'b1;
    settle();
    check_eq("t6 c1 rd", {31'b0, IMEM_RD}, 32'd1);
    check_eq("t6 c1 addr", IMEM_ADDR, 32'h0);
    tick(); tick(); settle();
    check_eq("t6 c3 valid", {31'b0, IF_VALID}, 32'd1);
    check_eq("t6 c3 pc", IF_PC, 32'h0);
    tick(); settle();
    check_eq("t6 c4 pc", IF_PC, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
